// File: rtl/pulse_delay_pkg.sv
// Shared types and default parameters for the pulse delay generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only). Macro PULSE_STRETCH_EN adds the EMIT state.
package pulse_delay_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DLY_W   = 16;
    localparam int DEF_WID_W   = 8;
    localparam int DEF_DLY_RST = 20;

    // Per-channel FSM; EMIT only exists when the output width is programmable.
`ifdef PULSE_STRETCH_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_EMIT  = 2'd2
    } chan_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1
    } chan_state_t;
`endif

endpackage

// File: rtl/pulse_delay_chan.sv
// One delay channel: rising edge on pulse_in -> registered pulse after D+1 cycles, W wide.
// Latency: D+1 cycles from the trigger edge; busy from the trigger edge.
// Backpressure: none; triggers while busy are dropped and flagged in overrun. Macro PULSE_STRETCH_EN enables width W.
module pulse_delay_chan
    import pulse_delay_pkg::*;
#(
    parameter int DLY_W   = DEF_DLY_W,
    parameter int WID_W   = DEF_WID_W,
    parameter int DLY_RST = DEF_DLY_RST
) (
    input  logic             alg_clk,
    input  logic             alg_rst_n,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic             cfg_wr,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic             ovr_clr,
    output logic             pulse_out,
    output logic             busy,
    output logic             overrun
);

    chan_state_t      state, state_nxt;
    logic [DLY_W-1:0] dly_cnt, dly_cnt_nxt, dly_shadow;
    logic             pulse_q, pulse_nxt;
    logic             in_prev, armed, trig;
    logic             last_cyc, load;
    logic             ovr_hit, ovr_hit_nxt, ovr_q;

    // armed stays low until pulse_in has been seen low once after reset,
    // so a level already high at reset release is not taken as an edge
    assign trig = pulse_in & ~in_prev & armed;

`ifdef PULSE_STRETCH_EN
    logic [WID_W-1:0] wid_shadow, wid_cnt, wid_cnt_nxt;
    logic [WID_W-1:0] wid_load;

    // W=0 behaves as W=1; counter holds remaining EMIT cycles minus one
    assign wid_load = (wid_shadow == '0) ? '0 : wid_shadow - 1'b1;
`else
    logic unused_width;
    assign unused_width = ^cfg_width;
`endif

    // next-state: detect final output cycle, accept trigger, count down without wrap
    always_comb begin
        state_nxt   = state;
        dly_cnt_nxt = dly_cnt;
        pulse_nxt   = pulse_q;
        last_cyc    = 1'b0;
`ifdef PULSE_STRETCH_EN
        wid_cnt_nxt = wid_cnt;
        if (state == ST_EMIT) begin
            last_cyc = (wid_cnt == '0);
        end
`else
        // without EMIT, pulse_q high in DELAY marks the single output cycle
        if (state == ST_DELAY) begin
            last_cyc = pulse_q;
        end
`endif
        load        = enable & trig & ((state == ST_IDLE) | last_cyc);
        ovr_hit_nxt = enable & trig & ~load;

        if (!enable) begin
            state_nxt = ST_IDLE;
            pulse_nxt = 1'b0;
        end else if (load) begin
            state_nxt   = ST_DELAY;
            dly_cnt_nxt = dly_shadow;
            pulse_nxt   = 1'b0;
`ifdef PULSE_STRETCH_EN
            wid_cnt_nxt = wid_load;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    pulse_nxt = 1'b0;
                end
                ST_DELAY: begin
`ifdef PULSE_STRETCH_EN
                    if (dly_cnt == '0) begin
                        state_nxt = ST_EMIT;
                        pulse_nxt = 1'b1;
                    end else begin
                        dly_cnt_nxt = dly_cnt - 1'b1;
                    end
`else
                    if (last_cyc) begin
                        state_nxt = ST_IDLE;
                        pulse_nxt = 1'b0;
                    end else if (dly_cnt == '0) begin
                        pulse_nxt = 1'b1;
                    end else begin
                        dly_cnt_nxt = dly_cnt - 1'b1;
                    end
`endif
                end
`ifdef PULSE_STRETCH_EN
                ST_EMIT: begin
                    if (last_cyc) begin
                        state_nxt = ST_IDLE;
                        pulse_nxt = 1'b0;
                    end else begin
                        wid_cnt_nxt = wid_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    pulse_nxt = 1'b0;
                end
            endcase
        end
    end

    // state, delay counter, edge history, shadow delay and sticky overrun
    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            state      <= ST_IDLE;
            dly_cnt    <= '0;
            pulse_q    <= 1'b0;
            in_prev    <= 1'b0;
            armed      <= 1'b0;
            ovr_hit    <= 1'b0;
            ovr_q      <= 1'b0;
            dly_shadow <= DLY_W'(DLY_RST);
        end else begin
            state   <= state_nxt;
            dly_cnt <= dly_cnt_nxt;
            pulse_q <= pulse_nxt;
            in_prev <= pulse_in;
            armed   <= armed | ~pulse_in;
            ovr_hit <= ovr_hit_nxt;
            // a set landing with a clear wins
            ovr_q   <= (ovr_q & ~ovr_clr) | ovr_hit;
            if (cfg_wr) begin
                dly_shadow <= cfg_delay;
            end
        end
    end

`ifdef PULSE_STRETCH_EN
    // width counter and shadow width
    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            wid_cnt    <= '0;
            wid_shadow <= WID_W'(1);
        end else begin
            wid_cnt <= wid_cnt_nxt;
            if (cfg_wr) begin
                wid_shadow <= cfg_width;
            end
        end
    end
`endif

    assign pulse_out = pulse_q;
    assign busy      = (state != ST_IDLE);
    assign overrun   = ovr_q;

endmodule

// File: rtl/pulse_delay_gen.sv
// Multi-channel pulse delay generator: config decode, overrun clear fan-out, NUM_CH channels.
// Latency: D+1 cycles trigger-to-output per channel; config takes effect at the next trigger.
// Backpressure: none; lost triggers set sticky overrun. Macro PULSE_STRETCH_EN enables output width.
module pulse_delay_gen
    import pulse_delay_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DLY_W   = DEF_DLY_W,
    parameter int WID_W   = DEF_WID_W,
    parameter int DLY_RST = DEF_DLY_RST
) (
    input  logic              alg_clk,
    input  logic              alg_rst_n,
    input  logic              enable,
    input  logic [NUM_CH-1:0] pulse_in,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [WID_W-1:0]  cfg_width,
    input  logic              ovr_clr,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] overrun
);

    logic [NUM_CH-1:0] ch_wr;

    // one-hot write decode; cfg_ch beyond the last channel matches nothing
    always_comb begin
        ch_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = cfg_we && (cfg_ch == 4'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pulse_delay_chan #(
            .DLY_W   (DLY_W),
            .WID_W   (WID_W),
            .DLY_RST (DLY_RST)
        ) u_chan (
            .alg_clk   (alg_clk),
            .alg_rst_n (alg_rst_n),
            .enable    (enable),
            .pulse_in  (pulse_in[g]),
            .cfg_wr    (ch_wr[g]),
            .cfg_delay (cfg_delay),
            .cfg_width (cfg_width),
            .ovr_clr   (ovr_clr),
            .pulse_out (pulse_out[g]),
            .busy      (busy[g]),
            .overrun   (overrun[g])
        );
    end

endmodule
